// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle control unit.
// master = control unit (drives enables), slave = datapath side.
interface multicycle_control_unit_if;
    logic [5:0] OP;
    logic [5:0] Func;
    logic       zero;
    logic       mem_ready;

    logic       PCwrite;
    logic       IRwrite;
    logic       REGwrite;
    logic       MEMwrite;
    logic       MEMread;
    logic       ALUsel;
    logic       ext;
    logic [2:0] Branch;
    logic [2:0] REGsel;
    logic [2:0] WDsel;
    logic [3:0] ALUcon;
    logic       MDstart;
    logic       MDop;
    logic [2:0] state;
    logic       md_busy;

    modport master (
        input  OP, Func, zero, mem_ready,
        output PCwrite, IRwrite, REGwrite, MEMwrite, MEMread, ALUsel, ext,
               Branch, REGsel, WDsel, ALUcon, MDstart, MDop, state, md_busy
    );

    modport slave (
        output OP, Func, zero, mem_ready,
        input  PCwrite, IRwrite, REGwrite, MEMwrite, MEMread, ALUsel, ext,
               Branch, REGsel, WDsel, ALUcon, MDstart, MDop, state, md_busy
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM with an optional multiply/divide wait phase.
// Enables are decoded from the current state and forced to 0 while reset is low.
module multicycle_control_unit #(
    parameter int MULT_LAT  = 5,
    parameter int DIV_LAT   = 10,
    parameter int ENABLE_MD = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);
    localparam bit MD_EN = (ENABLE_MD != 0);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        MD_WAIT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        I_ILLEGAL, I_ADDU, I_SUBU, I_SLT, I_JR, I_MULT, I_DIV, I_MFHI,
        I_MFLO, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL
    } instr_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd4;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    instr_e         instr;

    logic       pcw, irw, regw, memw, memr, alusel, ext_sel, mdstart, mdop, busy;
    logic [2:0] branch, regsel, wdsel;
    logic [3:0] alucon;

    always_comb begin
        instr = I_ILLEGAL;
        case (bus.OP)
            6'h00: begin
                case (bus.Func)
                    6'h21: instr = I_ADDU;
                    6'h23: instr = I_SUBU;
                    6'h2A: instr = I_SLT;
                    6'h08: instr = I_JR;
                    6'h18: if (MD_EN) instr = I_MULT;
                    6'h1A: if (MD_EN) instr = I_DIV;
                    6'h10: if (MD_EN) instr = I_MFHI;
                    6'h12: if (MD_EN) instr = I_MFLO;
                    default: ;
                endcase
            end
            6'h0D: instr = I_ORI;
            6'h23: instr = I_LW;
            6'h2B: instr = I_SW;
            6'h04: instr = I_BEQ;
            6'h0F: instr = I_LUI;
            6'h03: instr = I_JAL;
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d = FETCH;
        cnt_d   = cnt_q;
        pcw     = 1'b0;
        irw     = 1'b0;
        regw    = 1'b0;
        memw    = 1'b0;
        memr    = 1'b0;
        alusel  = 1'b0;
        ext_sel = 1'b0;
        mdstart = 1'b0;
        mdop    = 1'b0;
        busy    = 1'b0;
        branch  = 3'd0;
        regsel  = 3'd0;
        wdsel   = 3'd0;
        alucon  = ALU_ADD;

        case (state_q)
            FETCH: begin
                irw     = 1'b1;
                pcw     = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                if (instr == I_JAL)          state_d = WB;
                else if (instr == I_ILLEGAL) state_d = FETCH;
                else                         state_d = EXEC;
            end
            EXEC: begin
                case (instr)
                    I_ADDU: state_d = WB;
                    I_SUBU: begin alucon = ALU_SUB; state_d = WB; end
                    I_SLT:  begin alucon = ALU_SLT; state_d = WB; end
                    I_ORI:  begin alucon = ALU_OR;  alusel = 1'b1; state_d = WB; end
                    I_LUI:  begin alucon = ALU_LUI; alusel = 1'b1; state_d = WB; end
                    I_LW, I_SW: begin
                        alusel  = 1'b1;
                        ext_sel = 1'b1;
                        state_d = MEM;
                    end
                    // Subtract so the datapath's zero flag reflects rs == rt.
                    I_BEQ: begin alucon = ALU_SUB; branch = 3'd1; pcw = bus.zero; end
                    I_JR:  begin branch = 3'd3; pcw = 1'b1; end
                    I_MULT: begin
                        mdstart = 1'b1;
                        cnt_d   = MULT_LOAD;
                        state_d = MD_WAIT;
                    end
                    I_DIV: begin
                        mdstart = 1'b1;
                        mdop    = 1'b1;
                        cnt_d   = DIV_LOAD;
                        state_d = MD_WAIT;
                    end
                    I_MFHI, I_MFLO: state_d = WB;
                    default: ;
                endcase
            end
            MEM: begin
                if (instr == I_LW) memr = 1'b1;
                else               memw = 1'b1;
                if (!bus.mem_ready)        state_d = MEM;
                else if (instr == I_LW)    state_d = WB;
            end
            WB: begin
                regw = 1'b1;
                case (instr)
                    I_ADDU, I_SUBU, I_SLT: regsel = 3'd1;
                    I_MFHI: begin regsel = 3'd1; wdsel = 3'd3; end
                    I_MFLO: begin regsel = 3'd1; wdsel = 3'd4; end
                    I_LW:   wdsel = 3'd1;
                    I_JAL: begin
                        regsel = 3'd2;
                        wdsel  = 3'd2;
                        pcw    = 1'b1;
                        branch = 3'd2;
                    end
                    default: ;
                endcase
            end
            MD_WAIT: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = MD_WAIT;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: outputs are gated by reset so they drop at once, even though FETCH is the reset state.
    assign bus.PCwrite  = reset & pcw;
    assign bus.IRwrite  = reset & irw;
    assign bus.REGwrite = reset & regw;
    assign bus.MEMwrite = reset & memw;
    assign bus.MEMread  = reset & memr;
    assign bus.ALUsel   = reset & alusel;
    assign bus.ext      = reset & ext_sel;
    assign bus.MDstart  = reset & mdstart;
    assign bus.MDop     = reset & mdop;
    assign bus.md_busy  = reset & busy;
    assign bus.Branch   = reset ? branch : 3'd0;
    assign bus.REGsel   = reset ? regsel : 3'd0;
    assign bus.WDsel    = reset ? wdsel  : 3'd0;
    assign bus.ALUcon   = reset ? alucon : 4'd0;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three configurations, per-instruction expected
// cycle sequences built from the instruction-level timing rules.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] op_r, func_r;
    logic       zero_r, mem_ready_r;

    int tests_run    = 0;
    int tests_failed = 0;

    multicycle_control_unit_if if_a ();
    multicycle_control_unit_if if_b ();
    multicycle_control_unit_if if_c ();

    assign if_a.OP = op_r;  assign if_a.Func = func_r;  assign if_a.zero = zero_r;  assign if_a.mem_ready = mem_ready_r;
    assign if_b.OP = op_r;  assign if_b.Func = func_r;  assign if_b.zero = zero_r;  assign if_b.mem_ready = mem_ready_r;
    assign if_c.OP = op_r;  assign if_c.Func = func_r;  assign if_c.zero = zero_r;  assign if_c.mem_ready = mem_ready_r;

    multicycle_control_unit #(.MULT_LAT(5), .DIV_LAT(10), .ENABLE_MD(1)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
    multicycle_control_unit #(.MULT_LAT(1), .DIV_LAT(2),  .ENABLE_MD(1)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b));
    multicycle_control_unit #(.MULT_LAT(5), .DIV_LAT(10), .ENABLE_MD(0)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c));

    int cfg_mult [3] = '{5, 1, 5};
    int cfg_div  [3] = '{10, 2, 10};
    bit cfg_md   [3] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [2:0] state;
        logic       pcw, irw, regw, memw, memr, alusel, ext;
        logic [2:0] branch, regsel, wdsel;
        logic [3:0] alucon;
        logic       mdstart, mdop, busy;
    } obs_t;

    typedef enum {
        K_ILL, K_ADDU, K_SUBU, K_SLT, K_JR, K_MULT, K_DIV, K_MFHI, K_MFLO,
        K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL
    } kind_e;

    obs_t exp_q [$];
    obs_t mask_q [$];
    bit   mem_q [$];
    bit   rdy_q [$];

    // Instruction pool: 14 supported encodings followed by 3 unsupported ones; -1 = random Func.
    logic [5:0] pool_op [17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h00, 6'h3F, 6'h02};
    int         pool_fn [17] = '{'h21, 'h23, 'h2A, 'h08, 'h18, 'h1A, 'h10, 'h12,
                                 -1, -1, -1, -1, -1, -1, 'h20, -1, -1};

    function automatic obs_t get_obs(input int sel);
        case (sel)
            0: return {if_a.state, if_a.PCwrite, if_a.IRwrite, if_a.REGwrite, if_a.MEMwrite, if_a.MEMread,
                       if_a.ALUsel, if_a.ext, if_a.Branch, if_a.REGsel, if_a.WDsel, if_a.ALUcon,
                       if_a.MDstart, if_a.MDop, if_a.md_busy};
            1: return {if_b.state, if_b.PCwrite, if_b.IRwrite, if_b.REGwrite, if_b.MEMwrite, if_b.MEMread,
                       if_b.ALUsel, if_b.ext, if_b.Branch, if_b.REGsel, if_b.WDsel, if_b.ALUcon,
                       if_b.MDstart, if_b.MDop, if_b.md_busy};
            default: return {if_c.state, if_c.PCwrite, if_c.IRwrite, if_c.REGwrite, if_c.MEMwrite, if_c.MEMread,
                       if_c.ALUsel, if_c.ext, if_c.Branch, if_c.REGsel, if_c.WDsel, if_c.ALUcon,
                       if_c.MDstart, if_c.MDop, if_c.md_busy};
        endcase
    endfunction

    function automatic kind_e classify(input int cfg, input logic [5:0] o, input logic [5:0] f);
        kind_e k;
        bit md;
        k  = K_ILL;
        md = cfg_md[cfg];
        case (o)
            6'h00: case (f)
                6'h21: k = K_ADDU;
                6'h23: k = K_SUBU;
                6'h2A: k = K_SLT;
                6'h08: k = K_JR;
                6'h18: k = md ? K_MULT : K_ILL;
                6'h1A: k = md ? K_DIV  : K_ILL;
                6'h10: k = md ? K_MFHI : K_ILL;
                6'h12: k = md ? K_MFLO : K_ILL;
                default: k = K_ILL;
            endcase
            6'h0D: k = K_ORI;
            6'h23: k = K_LW;
            6'h2B: k = K_SW;
            6'h04: k = K_BEQ;
            6'h0F: k = K_LUI;
            6'h03: k = K_JAL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic obs_t fetch_rec();
        obs_t e;
        e     = '0;
        e.pcw = 1'b1;
        e.irw = 1'b1;
        return e;
    endfunction

    task automatic push(input obs_t e, input obs_t m, input bit is_mem, input bit rdy);
        exp_q.push_back(e);
        mask_q.push_back(m);
        mem_q.push_back(is_mem);
        rdy_q.push_back(rdy);
    endtask

    // Expected per-cycle outputs of one instruction, from its FETCH up to the next FETCH.
    task automatic build_expect(input int cfg, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input int waits);
        kind_e k;
        obs_t  e, m;
        int    lat;
        k = classify(cfg, o, f);
        exp_q.delete(); mask_q.delete(); mem_q.delete(); rdy_q.delete();
        push(fetch_rec(), '1, 1'b0, 1'b0);
        e = '0; e.state = 3'd1;
        push(e, '1, 1'b0, 1'b0);
        if (k == K_JAL) begin
            e = '0; e.state = 3'd4; e.regw = 1'b1; e.regsel = 3'd2; e.wdsel = 3'd2;
            e.pcw = 1'b1; e.branch = 3'd2;
            push(e, '1, 1'b0, 1'b0);
        end else if (k != K_ILL) begin
            e = '0; e.state = 3'd2; m = '1;
            case (k)
                K_SUBU: e.alucon = 4'd1;
                K_SLT:  e.alucon = 4'd3;
                K_ORI:  begin e.alucon = 4'd2; e.alusel = 1'b1; end
                K_LUI:  begin e.alucon = 4'd4; e.alusel = 1'b1; end
                K_LW, K_SW: begin e.alusel = 1'b1; e.ext = 1'b1; end
                K_BEQ:  begin e.branch = 3'd1; e.pcw = z; m.alucon = '0; end
                K_JR:   begin e.branch = 3'd3; e.pcw = 1'b1; end
                K_MULT: e.mdstart = 1'b1;
                K_DIV:  begin e.mdstart = 1'b1; e.mdop = 1'b1; end
                default: ;
            endcase
            push(e, m, 1'b0, 1'b0);
            case (k)
                K_BEQ, K_JR: ;
                K_LW, K_SW: begin
                    for (int i = 0; i <= waits; i++) begin
                        e = '0; e.state = 3'd3; e.memr = (k == K_LW); e.memw = (k == K_SW);
                        push(e, '1, 1'b1, (i == waits));
                    end
                    if (k == K_LW) begin
                        e = '0; e.state = 3'd4; e.regw = 1'b1; e.wdsel = 3'd1;
                        push(e, '1, 1'b0, 1'b0);
                    end
                end
                K_MULT, K_DIV: begin
                    lat = (k == K_MULT) ? cfg_mult[cfg] : cfg_div[cfg];
                    for (int i = 0; i < lat; i++) begin
                        e = '0; e.state = 3'd5; e.busy = 1'b1;
                        push(e, '1, 1'b0, 1'b0);
                    end
                end
                default: begin
                    e = '0; e.state = 3'd4; e.regw = 1'b1;
                    if (k inside {K_ADDU, K_SUBU, K_SLT, K_MFHI, K_MFLO}) e.regsel = 3'd1;
                    if (k == K_MFHI) e.wdsel = 3'd3;
                    if (k == K_MFLO) e.wdsel = 3'd4;
                    push(e, '1, 1'b0, 1'b0);
                end
            endcase
        end
    endtask

    // Drives one instruction cycle by cycle; ncyc > 0 stops early (used to abort with reset).
    task automatic run_instr(input int sel, input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int waits, input int ncyc);
        int   n;
        obs_t got;
        build_expect(sel, o, f, z, waits);
        n = exp_q.size();
        if (ncyc > 0 && ncyc < n) n = ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_r        = o;
            func_r      = f;
            zero_r      = z;
            mem_ready_r = mem_q[i] ? rdy_q[i] : 1'($urandom_range(0, 1));
            #1;
            got = get_obs(sel);
            tests_run++;
            if (((got ^ exp_q[i]) & mask_q[i]) !== '0) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, i, got, exp_q[i], mask_q[i]);
            end
        end
    endtask

    task automatic check_zero(input int sel, input string name);
        obs_t got;
        got = get_obs(sel);
        tests_run++;
        if (got !== '0) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, 26'h0);
        end
    endtask

    task automatic check_fetch(input int sel, input string name);
        obs_t got;
        @(negedge clk);
        #1;
        got = get_obs(sel);
        tests_run++;
        if (got !== fetch_rec()) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, fetch_rec());
        end
    endtask

    // Reset all DUTs; release just after a rising edge so the next edge executes FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        check_zero(2, "reset_c");
        @(posedge clk);
        #2 rst_n = 1'b1;
        check_fetch(0, "post_release_fetch");
        #2 rst_n = 1'b0;
        #1 check_zero(0, "async_reset_in_fetch");
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_addu();
        run_instr(0, "addu", 6'h00, 6'h21, 1'b0, 0, 0);
        run_instr(0, "subu", 6'h00, 6'h23, 1'b1, 0, 0);
        run_instr(0, "ori",  6'h0D, 6'h15, 1'b0, 0, 0);
    endtask

    task automatic test_lw_waits();
        run_instr(0, "lw_wait3", 6'h23, 6'h00, 1'b0, 3, 0);
        run_instr(0, "sw_wait0", 6'h2B, 6'h00, 1'b0, 0, 0);
        run_instr(0, "jal",      6'h03, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        run_instr(0, "beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(0, "beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(0, "jr",     6'h00, 6'h08, 1'b0, 0, 0);
    endtask

    task automatic test_div_mflo();
        run_instr(0, "div",  6'h00, 6'h1A, 1'b0, 0, 0);
        run_instr(0, "mflo", 6'h00, 6'h12, 1'b0, 0, 0);
        run_instr(0, "mult", 6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(0, "mfhi", 6'h00, 6'h10, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back_random();
        int         idx;
        logic [5:0] f;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 16);
            f   = (pool_fn[idx] < 0) ? 6'($urandom) : 6'(pool_fn[idx]);
            run_instr(0, "random", pool_op[idx], f, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
        end
    endtask

    task automatic test_reset_md();
        run_instr(0, "div_abort", 6'h00, 6'h1A, 1'b0, 0, 6);
        #2 rst_n = 1'b0;
        #1 check_zero(0, "reset_in_md_wait");
        @(posedge clk);
        #1 check_zero(0, "reset_hold_md");
        #1 rst_n = 1'b1;
        run_instr(0, "addu_after_md_abort", 6'h00, 6'h21, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mem();
        run_instr(0, "sw_abort", 6'h2B, 6'h00, 1'b0, 6, 5);
        #2 rst_n = 1'b0;
        #1 check_zero(0, "reset_in_mem");
        @(posedge clk);
        #1 check_zero(0, "reset_hold_mem");
        #1 rst_n = 1'b1;
        run_instr(0, "slt_after_mem_abort", 6'h00, 6'h2A, 1'b0, 0, 0);
    endtask

    task automatic test_md_disabled();
        do_reset();
        run_instr(2, "nomd_mult", 6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(2, "nomd_div",  6'h00, 6'h1A, 1'b0, 0, 0);
        run_instr(2, "nomd_mfhi", 6'h00, 6'h10, 1'b0, 0, 0);
        run_instr(2, "nomd_addu", 6'h00, 6'h21, 1'b0, 0, 0);
        check_fetch(2, "nomd_end_fetch");
    endtask

    task automatic test_lat_one();
        do_reset();
        run_instr(1, "lat1_mult", 6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(1, "lat2_div",  6'h00, 6'h1A, 1'b0, 0, 0);
        run_instr(1, "lat1_mult_again", 6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(1, "lat_lui",   6'h0F, 6'h3C, 1'b0, 0, 0);
        check_fetch(1, "lat_end_fetch");
    endtask

    initial begin
        rst_n       = 1'b0;
        op_r        = 6'h00;
        func_r      = 6'h00;
        zero_r      = 1'b0;
        mem_ready_r = 1'b0;
        test_reset();
        test_addu();
        test_lw_waits();
        test_beq();
        test_div_mflo();
        test_back_to_back_random();
        test_reset_md();
        test_reset_mem();
        test_md_disabled();
        test_lat_one();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MULT_LAT, default 5, cycles spent in MD_WAIT for mult (>=1).
REQ-002 Parameter DIV_LAT, default 10, cycles spent in MD_WAIT for div (>=1).
REQ-003 Parameter ENABLE_MD, default 1, enables mult/div/mfhi/mflo decode.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 OP  in  6  opcode from instruction register, valid from DECODE onward.
REQ-008 Func  in  6  funct field from instruction register.
REQ-009 zero  in  1  ALU equality flag for beq.
REQ-010 mem_ready  in  1  data-memory completion strobe.
REQ-011 PCwrite, IRwrite, REGwrite, MEMwrite, MEMread  out  1 each  write/read enables.
REQ-012 ALUsel  out  1  ALU B = immediate; ext  out  1  sign-extend (else zero-extend).
REQ-013 Branch  out  3  0 pc+4, 1 beq, 2 jal, 3 jr.
REQ-014 REGsel  out  3  0 rt, 1 rd, 2 $31.
REQ-015 WDsel  out  3  0 alu, 1 mem, 2 pc+4, 3 hi, 4 lo.
REQ-016 ALUcon  out  4  0 add, 1 sub, 2 or, 3 slt, 4 lui.
REQ-017 MDstart  out  1  one-cycle start pulse; MDop  out  1  0 mult, 1 div.
REQ-018 state  out  3  current state code; md_busy  out  1  high in MD_WAIT.

Function
REQ-019 Decode: rtype OP=0x00 with Func addu 0x21, subu 0x23, slt 0x2A, jr 0x08, mult 0x18, div 0x1A, mfhi 0x10, mflo 0x12; ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, jal 0x03.
REQ-020 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MD_WAIT=5; codes 6,7 SHALL return to FETCH next cycle.
REQ-021 FETCH: IRwrite=1, PCwrite=1, Branch=0; next DECODE.
REQ-022 DECODE: no enables; jal -> WB; illegal/undecoded (incl. MD ops when ENABLE_MD=0) -> FETCH; else -> EXEC.
REQ-023 EXEC: ALUcon/ALUsel/ext per op (ori,lui zero-ext; lw,sw sign-ext; addu/lw/sw add); beq: Branch=1, PCwrite=zero, -> FETCH; jr: Branch=3, PCwrite=1, -> FETCH; lw/sw -> MEM; mult/div: MDstart=1, MDop set, -> MD_WAIT; others -> WB.
REQ-024 MEM: MEMread=1 (lw) or MEMwrite=1 (sw) held until mem_ready=1; on that cycle sw -> FETCH, lw -> WB; mem_ready=0 stays in MEM indefinitely.
REQ-025 WB: REGwrite=1 for exactly one cycle; REGsel rd for addu/subu/slt/mfhi/mflo, $31 for jal, rt otherwise; WDsel mem for lw, pc+4 for jal, hi/lo for mfhi/mflo, else alu; jal also PCwrite=1, Branch=2; -> FETCH.
REQ-026 MD_WAIT: counter loaded with LAT-1 on EXEC exit, decrements each cycle; when counter==0 -> FETCH; md_busy=1 throughout; LAT=1 gives exactly one MD_WAIT cycle.
REQ-027 Counter width SHALL be clog2(max(MULT_LAT,DIV_LAT))+1 bits, no wrap.
REQ-028 Latencies (cycles FETCH to next FETCH): ALU/mfhi/mflo 4, lw 5+waits, sw 4+waits, beq/jr 3, jal 3, mult 3+MULT_LAT, div 3+DIV_LAT.
REQ-029 All enables SHALL be 0 in any state/op not listed above; Branch, REGsel, WDsel, ALUcon default 0.

Reset
REQ-030 reset=0 SHALL immediately force state=FETCH, counter=0, and all outputs to 0 (including IRwrite/PCwrite), independent of clk.
REQ-031 Reset asserted mid-MEM or mid-MD_WAIT SHALL abort without any REGwrite/MEMwrite pulse; first post-release edge executes FETCH.

Verification
REQ-032 addu (OP=0,Func=0x21) -> states 0,1,2,4,0; REGwrite=1 only in WB with REGsel=1, WDsel=0.
REQ-033 lw with mem_ready low 3 cycles -> MEMread=1 for 4 cycles, then WB with WDsel=1, REGsel=0; total 8 cycles.
REQ-034 beq zero=0 then zero=1 -> PCwrite=0 then 1 in EXEC, Branch=1, 3 cycles each.
REQ-035 div with DIV_LAT=10 -> MDstart pulse 1 cycle, MDop=1, md_busy high 10 cycles, 13 cycles total; mflo next -> WB with WDsel=4.
REQ-036 ENABLE_MD=0, mult -> DECODE returns to FETCH, no MDstart, 2 cycles.
REQ-037 reset low during MD_WAIT cycle 3 -> all outputs 0 asynchronously, state=0 after release.
